decode_issue: RTL
=================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set register and operand data width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL mark that in_instr is valid.
REQ-005 in_ready  output  1  SHALL signal that the instruction is accepted this cycle.
REQ-006 in_instr  input  16  SHALL carry the instruction word.
REQ-007 S1, S2  output  3 each  SHALL drive the register file read addresses.
REQ-008 V1, V2  input  DATA_W each  SHALL be the asynchronous register file read data.
REQ-009 wb_en, wb_addr[2:0], wb_data[DATA_W-1:0]  input  SHALL be the writeback port that also drives the register file write (RW, D, WV).
REQ-010 out_valid  output  1;  out_ready  input  1  SHALL form the downstream handshake.
REQ-011 out_op[3:0], out_dst[2:0], out_wr, out_a, out_b, out_imm (DATA_W)  output  SHALL be the registered issue bundle.
REQ-012 busy  output  8  SHALL expose the scoreboard (bit n = register n has a pending write).

Function
REQ-013 Fields SHALL be: op=[15:12], dst=[11:9], src1=[8:6], src2=[5:3], imm6=[5:0].
REQ-014 S1=src1 and S2=src2 SHALL be combinational from in_instr, regardless of in_valid.
REQ-015 Opcodes: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (read src1+src2, write dst); 6 ADDI, 7 LD (read src1, write dst); 8 ST, 9 BEQ (read src1+src2, no write); 10-15 SHALL decode as NOP.
REQ-016 out_imm SHALL be imm6 sign-extended to DATA_W; it is 0 for ops other than 6/7/8/9.
REQ-017 hazard SHALL be asserted when any source the op uses has busy=1 and is not matched by wb_en&&wb_addr this cycle, or when the op writes and busy[dst]=1 and dst is not matched by the same writeback.
REQ-018 in_ready SHALL be !hazard && (!out_valid || out_ready); issue = in_valid && in_ready.
REQ-019 On issue the output bundle SHALL load at the next edge (1-cycle latency); out_a/out_b SHALL take wb_data when wb_en and wb_addr equals that source, else V1/V2.
REQ-020 Operands not used by the op SHALL load as 0.
REQ-021 out_valid SHALL set on issue, clear on out_ready without issue, and hold otherwise; the bundle SHALL stay stable while out_valid && !out_ready.
REQ-022 On issue of a writing op busy[dst] SHALL set; wb_en SHALL clear busy[wb_addr]; set SHALL win on the same address in the same cycle.
REQ-023 wb_en to a non-busy address SHALL be ignored without error.
REQ-024 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-025 While rst=1 at an edge: out_valid=0, busy=0, all bundle fields=0; in_ready SHALL evaluate from the cleared state.
REQ-026 rst SHALL override a concurrent issue or writeback; pending writes are discarded.

Structure
REQ-027 Opcode constants, field bit positions and op-class predicates (uses_src1, uses_src2, writes_dst) SHALL live in a shared package.
REQ-028 The 8-bit busy vector with set/clear priority SHALL be a sub-module named scoreboard.
REQ-029 Target size 120-400 lines RTL; no latches; no multi-driven nets.

Verification
REQ-030 Reset: rst=1 one cycle -> out_valid=0, busy=0x00, in_ready=1 after release.
REQ-031 ADD r3,r1,r2 with r1=5,r2=4 -> next cycle out_valid=1, out_a=5, out_b=4, out_dst=3, out_wr=1, busy=0x08.
REQ-032 RAW: SUB r4,r3,r1 after REQ-031 -> in_ready=0 until wb_en=1,wb_addr=3,wb_data=9; that cycle issues, out_a=9, busy=0x10.
REQ-033 Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, bundle unchanged; out_ready=1 -> queued instruction issues next edge.
REQ-034 ADDI r2,r1,imm6=0x3F -> out_imm=0xFF, out_b=0; opcode 0xC -> out_wr=0, busy unchanged.
REQ-035 Reset mid-operation with busy=0x18, out_valid=1 -> next cycle busy=0x00, out_valid=0.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared decode definitions: opcode values, instruction field positions and
// op-class predicates used by the issue stage.
package decode_issue_pkg;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int DST_HI  = 11;
  localparam int DST_LO  = 9;
  localparam int SRC1_HI = 8;
  localparam int SRC1_LO = 6;
  localparam int SRC2_HI = 5;
  localparam int SRC2_LO = 3;
  localparam int IMM_HI  = 5;
  localparam int IMM_LO  = 0;
  localparam int IMM_W   = 6;
  localparam int NREGS   = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_BEQ  = 4'd9
  } op_e;

  // Opcodes 10..15 are reserved and behave exactly like NOP.
  function automatic op_e decode_op(input logic [3:0] raw);
    if (raw <= 4'd9) return op_e'(raw);
    return OP_NOP;
  endfunction

  function automatic logic uses_src1(input op_e op);
    return (op != OP_NOP);
  endfunction

  function automatic logic uses_src2(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST, OP_BEQ: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic writes_dst(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LD: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic has_imm(input op_e op);
    case (op)
      OP_ADDI, OP_LD, OP_ST, OP_BEQ: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. An issue sets the
// destination bit, a writeback clears its bit, and a set wins when both
// target the same register in the same cycle.
module scoreboard
  import decode_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [2:0]       set_addr,
  input  logic             clr_en,
  input  logic [2:0]       clr_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // One-hot masks for the register being claimed and the one being released
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // Clear first, then set, so a same-cycle set on the same bit survives
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode and issue stage: splits the instruction word, reads operands from
// an external register file (with writeback bypass), stalls on scoreboard
// hazards and presents a registered issue bundle behind a valid/ready pair.
module decode_issue #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [2:0]        S1,
  output logic [2:0]        S2,
  input  logic [DATA_W-1:0] V1,
  input  logic [DATA_W-1:0] V2,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [2:0]        out_dst,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [7:0]        busy
);

  import decode_issue_pkg::*;

  op_e                      op_p0;
  logic [2:0]               dst_p0;
  logic [2:0]               src1_p0;
  logic [2:0]               src2_p0;
  logic signed [IMM_W-1:0]  imm6_p0;
  logic                     u1_p0, u2_p0, wr_p0, imm_en_p0;
  logic                     fwd1_p0, fwd2_p0, fwdd_p0;
  logic                     hazard_p0;
  logic                     issue_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0]        a_p0, b_p0;

  // Sign extension of the 6-bit immediate to the datapath width
  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  assign S1 = in_instr[SRC1_HI:SRC1_LO];
  assign S2 = in_instr[SRC2_HI:SRC2_LO];

  // Stage p0: decode, hazard check and operand selection (combinational)
  always_comb begin
    op_p0     = decode_op(in_instr[OP_HI:OP_LO]);
    dst_p0    = in_instr[DST_HI:DST_LO];
    src1_p0   = in_instr[SRC1_HI:SRC1_LO];
    src2_p0   = in_instr[SRC2_HI:SRC2_LO];
    imm6_p0   = in_instr[IMM_HI:IMM_LO];
    u1_p0     = uses_src1(op_p0);
    u2_p0     = uses_src2(op_p0);
    wr_p0     = writes_dst(op_p0);
    imm_en_p0 = has_imm(op_p0);
    fwd1_p0   = wb_en && (wb_addr == src1_p0);
    fwd2_p0   = wb_en && (wb_addr == src2_p0);
    fwdd_p0   = wb_en && (wb_addr == dst_p0);
    // A writeback landing this cycle resolves the matching pending write
    hazard_p0 = (u1_p0 && busy[src1_p0] && !fwd1_p0) ||
                (u2_p0 && busy[src2_p0] && !fwd2_p0) ||
                (wr_p0 && busy[dst_p0]  && !fwdd_p0);
    in_ready  = !hazard_p0 && (!out_valid || out_ready);
    issue_p0  = in_valid && in_ready;
    imm_p0    = imm_en_p0 ? sext_imm(imm6_p0) : '0;
    a_p0      = '0;
    b_p0      = '0;
    if (u1_p0) a_p0 = fwd1_p0 ? wb_data : V1;
    if (u2_p0) b_p0 = fwd2_p0 ? wb_data : V2;
  end

  // Stage p0 -> output: issue bundle and its valid, held while stalled downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_dst   <= '0;
      out_wr    <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
    end else if (issue_p0) begin
      out_valid <= 1'b1;
      out_op    <= op_p0;
      out_dst   <= wr_p0 ? dst_p0 : 3'd0;
      out_wr    <= wr_p0;
      out_a     <= a_p0;
      out_b     <= b_p0;
      out_imm   <= imm_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_p0 && wr_p0),
    .set_addr (dst_p0),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .busy     (busy)
  );

endmodule
